// File: rtl/simon_input_conditioner.sv
// simon_input_conditioner
// Front-end for the Simon game. Brings the advance button, four pattern
// switches and the level switch into sysclk, debounces each channel, and
// presents a clean button level (uclk) plus a pattern bus that is frozen
// while the button is held so the datapath always samples a stable pattern.
module simon_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       pclk_raw,
    input  logic [3:0] pattern_raw,
    input  logic       level_raw,
    output logic       uclk,
    output logic       press_pulse,
    output logic [3:0] pattern_out,
    output logic       level_out
);

    // Channel map: [0] button, [4:1] pattern, [5] level
    localparam int NCH = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } btn_state_t;

    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] s1_r;
    logic [NCH-1:0] s2_r;
    logic [NCH-1:0] clean_r;
    logic [NCH-1:0] commit_s;
    logic [CNT_W-1:0] cnt_r [NCH];
    btn_state_t     state_r;

    assign raw_s = {level_raw, pattern_raw, pclk_raw};

    // A channel commits when its synchronised value has disagreed with the
    // clean value for the full debounce window.
    always_comb begin
        commit_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if ((s2_r[i] != clean_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                commit_s[i] = 1'b1;
            end else begin
                commit_s[i] = 1'b0;
            end
        end
    end

    // Two-flop synchroniser for every asynchronous raw input
    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1_r <= {NCH{1'b0}};
            s2_r <= {NCH{1'b0}};
        end else begin
            s1_r <= raw_s;
            s2_r <= s1_r;
        end
    end

    // Per-channel debounce counter; any agreement with clean restarts the count
    always_ff @(posedge sysclk) begin
        if (rst) begin
            clean_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2_r[i] == clean_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (commit_s[i]) begin
                    clean_r[i] <= s2_r[i];
                    cnt_r[i]   <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Button FSM: uclk follows the committed button level, pulse only on press
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r     <= ST_UP;
            uclk        <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            case (state_r)
                ST_UP: begin
                    if (commit_s[0] && s2_r[0]) begin
                        state_r     <= ST_DOWN;
                        uclk        <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        uclk        <= 1'b0;
                        press_pulse <= 1'b0;
                    end
                end
                ST_DOWN: begin
                    press_pulse <= 1'b0;
                    if (commit_s[0] && !s2_r[0]) begin
                        state_r <= ST_UP;
                        uclk    <= 1'b0;
                    end else begin
                        uclk    <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_UP;
                    uclk        <= 1'b0;
                    press_pulse <= 1'b0;
                end
            endcase
        end
    end

    // Pattern bus tracks the clean pattern while the button is up (using the
    // pre-edge uclk, so the press cycle still loads) and holds while it is down
    always_ff @(posedge sysclk) begin
        if (rst) begin
            pattern_out <= 4'b0000;
        end else if (!uclk) begin
            pattern_out <= clean_r[4:1];
        end else begin
            pattern_out <= pattern_out;
        end
    end

    // Level switch has no freeze: expose its clean register directly
    assign level_out = clean_r[5];

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Testbench for simon_input_conditioner with DEBOUNCE_CYCLES=4.
// A sliding-window reference model predicts every output each cycle;
// directed scenarios add explicit latency / pulse-count expectations.
module tb_simon_input_conditioner;

    localparam int D   = 4;
    localparam int CW  = 3;
    localparam int NCH = 6;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       pclk_raw;
    logic [3:0] pattern_raw;
    logic       level_raw;
    logic       uclk;
    logic       press_pulse;
    logic [3:0] pattern_out;
    logic       level_out;

    int total = 0;
    int bad   = 0;

    // Reference model state: raw sample history per channel (index 0 newest)
    bit         hist [NCH][D+2];
    bit         m_clean [NCH];
    bit         m_uclk;
    bit         m_press;
    logic [3:0] m_pat;
    bit         m_level;

    simon_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .pclk_raw   (pclk_raw),
        .pattern_raw(pattern_raw),
        .level_raw  (level_raw),
        .uclk       (uclk),
        .press_pulse(press_pulse),
        .pattern_out(pattern_out),
        .level_out  (level_out)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit raw_bit(input int ch);
        if (ch == 0) return pclk_raw;
        else if (ch == 5) return level_raw;
        else return pattern_raw[ch-1];
    endfunction

    // A channel flips when the D synchronised samples seen before this edge
    // (raw samples taken 2..D+1 edges ago) all agree and differ from clean.
    task automatic model_edge();
        bit         old_uclk;
        logic [3:0] old_pat;
        bit         same;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int j = 0; j < D + 2; j++) hist[c][j] = 1'b0;
                m_clean[c] = 1'b0;
            end
            m_uclk = 1'b0; m_press = 1'b0; m_pat = 4'h0; m_level = 1'b0;
        end else begin
            old_uclk = m_uclk;
            old_pat  = {m_clean[4], m_clean[3], m_clean[2], m_clean[1]};
            m_press  = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                same = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[c][j] != hist[c][1]) same = 1'b0;
                if (same && (hist[c][1] != m_clean[c])) begin
                    m_clean[c] = hist[c][1];
                    if (c == 0 && m_clean[0]) m_press = 1'b1;
                end
                for (int j = D + 1; j >= 1; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = raw_bit(c);
            end
            if (!old_uclk) m_pat = old_pat;
            m_uclk  = m_clean[0];
            m_level = m_clean[5];
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        check_val("uclk", uclk, m_uclk);
        check_val("press_pulse", press_pulse, m_press);
        check_val("pattern_out", pattern_out, m_pat);
        check_val("level_out", level_out, m_level);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run n steps; report first step index (1-based) with uclk=1 and pulse count
    task automatic watch_btn(input int n, output int first, output int pulses);
        first = 0; pulses = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (press_pulse) pulses++;
            if (uclk && first == 0) first = i;
        end
    endtask

    initial begin
        int   first;
        int   pulses;
        int   fell;
        logic prev_u;

        // 1. Reset with all raw inputs high
        rst = 1'b1; pclk_raw = 1'b1; pattern_raw = 4'hF; level_raw = 1'b1;
        run(3);
        rst = 1'b0;
        step();
        check_val("rst_uclk", uclk, 1'b0);
        check_val("rst_pulse", press_pulse, 1'b0);
        check_val("rst_pattern", pattern_out, 4'h0);
        check_val("rst_level", level_out, 1'b0);
        pclk_raw = 1'b0; pattern_raw = 4'h0; level_raw = 1'b0;
        run(12);

        // 2. Clean press
        pclk_raw = 1'b1;
        watch_btn(12, first, pulses);
        check_val("press_latency", first, 6);
        check_val("press_pulses", pulses, 1);
        pclk_raw = 1'b0;
        watch_btn(12, first, pulses);
        check_val("release_pulses", pulses, 0);
        check_val("release_uclk", uclk, 1'b0);

        // 3. Bounce rejection: 1,1,0,0,1,1,0,0 then steady 1
        first = 0; pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            pclk_raw = (i >= 9) ? 1'b1 : ((((i - 1) / 2) % 2) == 0);
            step();
            if (press_pulse) pulses++;
            if (uclk && first == 0) first = i;
        end
        check_val("bounce_latency", first, 14);
        check_val("bounce_pulses", pulses, 1);
        pclk_raw = 1'b0;
        run(12);

        // 4. Pattern freeze
        pattern_raw = 4'b0010;
        run(10);
        pclk_raw = 1'b1;
        run(3);
        pattern_raw = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            step();
            if (uclk) check_val("freeze_hold", pattern_out, 4'b0010);
        end
        pclk_raw = 1'b0;
        fell = 0; prev_u = uclk;
        for (int i = 0; i < 16 && fell == 0; i++) begin
            step();
            if (prev_u && !uclk) fell = 1;
            prev_u = uclk;
        end
        check_val("release_seen", fell, 1);
        check_val("pattern_at_fall", pattern_out, 4'b0010);
        step();
        check_val("pattern_after_fall", pattern_out, 4'b1000);
        run(8);

        // 5. Reset mid-count
        pclk_raw = 1'b1;
        run(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        watch_btn(12, first, pulses);
        check_val("rst_mid_latency", first, 6);
        pclk_raw = 1'b0;
        run(12);

        // 6. Level switch with single-cycle glitch
        first = 0;
        for (int i = 1; i <= 16; i++) begin
            level_raw = (i == 3) ? 1'b0 : 1'b1;
            step();
            if (level_out && first == 0) first = i;
        end
        check_val("level_latency", first, 9);

        // Randomised phases against the model
        for (int k = 0; k < 300; k++) begin
            pclk_raw    = 1'($urandom_range(0, 1));
            pattern_raw = 4'($urandom_range(0, 15));
            level_raw   = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 29) == 0);
            if (rst) begin
                step();
                rst = 1'b0;
            end
            run($urandom_range(1, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
